// File: rtl/snn_pkg.sv
// Shared types for the SNN run-level step scheduler.
package snn_pkg;

  localparam int SNN_TA = 3;
  localparam int SNN_NW = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INJECT    = 3'd1,
    S_STEP      = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_FINISH    = 3'd4
  } sched_state_t;

  typedef struct packed {
    logic [SNN_TA-1:0] block;
    logic [SNN_NW-1:0] neuron;
    logic              is_null;
    logic              last;
  } snn_stim_ev_t;

endpackage

// File: rtl/snn_step_scheduler.sv
// Run-level sequencer: injects stimulus events as force pulses, pulses time_step,
// then waits (with settle and timeout) for the network's done level.
module snn_step_scheduler
  import snn_pkg::*;
#(
  parameter int T       = 8,
  parameter int N       = 16,
  parameter int TA      = 3,
  parameter int STEP_W  = 16,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 4096,
  localparam int NW     = $clog2(N)
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              abort,
  input  logic              ev_valid,
  output logic              ev_ready,
  input  logic [TA-1:0]     ev_block,
  input  logic [NW-1:0]     ev_neuron,
  input  logic              ev_null,
  input  logic              ev_last,
  output logic              force_spike_en,
  output logic [TA-1:0]     force_spike_block_select,
  output logic [NW-1:0]     force_spike_neuron_select,
  output logic              time_step,
  input  logic              done,
  output logic              busy,
  output logic [STEP_W-1:0] step_count,
  output logic              run_done,
  output logic              timeout_err
);

  localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] SETTLE_C = WAIT_W'(SETTLE);
  localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [TA:0]       T_LIM    = (TA + 1)'(T);

  sched_state_t      r_state, w_next;
  logic [STEP_W-1:0] r_num_steps;
  logic [STEP_W-1:0] r_step_count;
  logic [STEP_W-1:0] w_count_sat;
  logic [WAIT_W-1:0] r_wait;
  logic              r_force_en;
  logic [TA-1:0]     r_blk;
  logic [NW-1:0]     r_nrn;
  logic              r_time_step;
  logic              r_timeout_err;

  logic w_abort;
  logic w_start;
  logic w_fire;
  logic w_count_inc;
  logic w_timeout;
  logic w_blk_ok;

  assign w_abort     = abort && (r_state != S_IDLE);
  assign w_count_sat = (&r_step_count) ? r_step_count : r_step_count + 1'b1;
  assign w_blk_ok    = {1'b0, ev_block} < T_LIM;

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_fire      = 1'b0;
    w_count_inc = 1'b0;
    w_timeout   = 1'b0;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            w_start = 1'b1;
            w_next  = (num_steps == '0) ? S_FINISH : S_INJECT;
          end
        end
        S_INJECT: begin
          if (ev_valid) begin
            w_fire = !ev_null && w_blk_ok;
            if (ev_last) w_next = S_STEP;
          end
        end
        S_STEP: w_next = S_WAIT_DONE;
        S_WAIT_DONE: begin
          // done only counts once the settle window has elapsed; it wins over a same-cycle timeout
          if (r_wait >= SETTLE_C && done) begin
            w_count_inc = 1'b1;
            w_next      = (w_count_sat == r_num_steps) ? S_FINISH : S_INJECT;
          end else if (r_wait >= TMO_LAST) begin
            w_timeout = 1'b1;
            w_next    = S_IDLE;
          end
        end
        S_FINISH: w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_num_steps   <= '0;
      r_step_count  <= '0;
      r_wait        <= '0;
      r_force_en    <= 1'b0;
      r_blk         <= '0;
      r_nrn         <= '0;
      r_time_step   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_force_en  <= w_fire;
      r_time_step <= (r_state == S_STEP) && !w_abort;
      if (w_fire) begin
        r_blk <= ev_block;
        r_nrn <= ev_neuron;
      end
      if (r_state == S_WAIT_DONE) r_wait <= r_wait + 1'b1;
      else                        r_wait <= '0;
      if (w_start) begin
        r_num_steps   <= num_steps;
        r_step_count  <= '0;
        r_timeout_err <= 1'b0;
      end
      if (w_count_inc) r_step_count  <= w_count_sat;
      if (w_timeout)   r_timeout_err <= 1'b1;
    end
  end

  assign ev_ready                  = (r_state == S_INJECT) && !abort;
  assign force_spike_en            = r_force_en;
  assign force_spike_block_select  = r_blk;
  assign force_spike_neuron_select = r_nrn;
  assign time_step                 = r_time_step;
  assign busy                      = (r_state != S_IDLE);
  assign step_count                = r_step_count;
  assign run_done                  = (r_state == S_FINISH) && !abort;
  assign timeout_err               = r_timeout_err;

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Scoreboard bench for snn_step_scheduler: random runs against a step/event-level model.
module tb_snn_step_scheduler;
  import snn_pkg::*;

  localparam int T = 6, N = 16, TA = 3, NW = 4, STEP_W = 16, SETTLE = 2, TIMEOUT = 40;

  logic              clk, reset, start, abort, ev_valid, ev_ready, ev_null, ev_last;
  logic [STEP_W-1:0] num_steps, step_count;
  logic [TA-1:0]     ev_block, force_spike_block_select;
  logic [NW-1:0]     ev_neuron, force_spike_neuron_select;
  logic              force_spike_en, time_step, done, busy, run_done, timeout_err;

  snn_step_scheduler #(.T(T), .N(N), .TA(TA), .STEP_W(STEP_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .num_steps(num_steps), .abort(abort),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_block(ev_block), .ev_neuron(ev_neuron),
    .ev_null(ev_null), .ev_last(ev_last), .force_spike_en(force_spike_en),
    .force_spike_block_select(force_spike_block_select),
    .force_spike_neuron_select(force_spike_neuron_select), .time_step(time_step),
    .done(done), .busy(busy), .step_count(step_count), .run_done(run_done),
    .timeout_err(timeout_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, ready_viol = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  // Expected responses: force pulses, time_step pulses, run_done pulses
  typedef struct { int blk; int nrn; int cyc; } fexp_t;
  typedef struct { int cnt; int cyc; } texp_t;
  fexp_t q_force[$];
  texp_t q_ts[$];
  texp_t q_run[$];
  int model_cnt;

  // Network done model
  typedef enum { D_RAND, D_HIGH, D_LOW } dmode_t;
  dmode_t dmode = D_RAND;

  initial begin
    int armed, d_at, ck_at, prev, dly;
    armed = 0; d_at = 0; ck_at = 0; prev = 0;
    done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        armed = 0;
      end else if (time_step) begin
        dly = (dmode == D_HIGH) ? 0 : $urandom_range(0, 5);
        if (dmode == D_HIGH) done = 1'b1;
        else                 done = (dmode == D_RAND && dly == 0);
        if (dmode != D_LOW) begin
          armed = 1;
          d_at  = cyc + dly;
          ck_at = cyc + ((dly > SETTLE) ? dly : SETTLE) + 1;
          prev  = int'(step_count);
        end
      end else if (armed != 0) begin
        if (cyc == d_at) done = 1'b1;
        if (cyc == ck_at - 1) chk("settle_hold", step_count, prev);
        if (cyc == ck_at) begin
          chk("step_inc", step_count, prev + 1);
          armed = 0;
        end
      end
    end
  end

  // Monitor: pops and compares whenever the DUT presents a pulse
  int last_blk = 0, last_nrn = 0;
  always @(negedge clk) begin
    if (reset) begin
      last_blk = 0;
      last_nrn = 0;
    end else begin
      if (ev_ready && (!busy || time_step || run_done)) ready_viol++;
      if (force_spike_en) begin
        if (q_force.size() == 0) begin
          chk("force_unexpected", 1, 0);
        end else begin
          fexp_t f;
          f = q_force.pop_front();
          chk("force_blk", force_spike_block_select, f.blk);
          chk("force_nrn", force_spike_neuron_select, f.nrn);
          chk("force_cyc", cyc, f.cyc);
        end
        last_blk = int'(force_spike_block_select);
        last_nrn = int'(force_spike_neuron_select);
      end else if (int'(force_spike_block_select) != last_blk || int'(force_spike_neuron_select) != last_nrn) begin
        errors++;
        $display("FAIL select_hold: got %0d/%0d expected %0d/%0d", force_spike_block_select,
                 force_spike_neuron_select, last_blk, last_nrn);
      end
      if (time_step) begin
        if (q_ts.size() == 0) begin
          chk("ts_unexpected", 1, 0);
        end else begin
          texp_t e;
          e = q_ts.pop_front();
          chk("ts_cyc", cyc, e.cyc);
          chk("ts_cnt", step_count, e.cnt);
        end
      end
      if (run_done) begin
        if (q_run.size() == 0) begin
          chk("run_done_unexpected", 1, 0);
        end else begin
          texp_t e;
          e = q_run.pop_front();
          chk("run_cnt", step_count, e.cnt);
          if (e.cyc >= 0) chk("run_cyc", cyc, e.cyc);
        end
      end
    end
  end

  // Stimulus tasks: entered and left just after a falling edge
  task automatic start_run(input int n);
    start     = 1'b1;
    num_steps = STEP_W'(n);
    model_cnt = 0;
    q_run.push_back('{n, (n == 0) ? cyc + 1 : -1});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_ev(input snn_stim_ev_t ev);
    int g, k;
    g = 0;
    ev_valid  = 1'b1;
    ev_block  = ev.block;
    ev_neuron = ev.neuron;
    ev_null   = ev.is_null;
    ev_last   = ev.last;
    while (!ev_ready) begin
      @(negedge clk);
      g++;
      if (g > 3 * TIMEOUT) begin
        bad("ev_ready_wait");
        ev_valid = 1'b0;
        return;
      end
    end
    k = cyc;
    if (!ev.is_null && int'(ev.block) < T) q_force.push_back('{int'(ev.block), int'(ev.neuron), k + 1});
    if (ev.last) begin
      q_ts.push_back('{model_cnt, k + 2});
      model_cnt++;
    end
    @(negedge clk);
  endtask

  function automatic snn_stim_ev_t mk(input int b, input int n, input bit nul, input bit lst);
    snn_stim_ev_t e;
    e.block   = SNN_TA'(b);
    e.neuron  = SNN_NW'(n);
    e.is_null = nul;
    e.last    = lst;
    return e;
  endfunction

  task automatic send_step(input int nev);
    for (int i = 0; i < nev; i++) begin
      send_ev(mk($urandom_range(0, 7), $urandom_range(0, N - 1), ($urandom_range(0, 4) == 0), (i == nev - 1)));
      if ($urandom_range(0, 2) == 0) begin
        ev_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    ev_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int g;
    g = 0;
    while (busy) begin
      @(negedge clk);
      g++;
      if (g > 4 * TIMEOUT) begin
        bad(nm);
        return;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ts(output int w0);
    int g;
    g = 0;
    while (!time_step && g < 10) begin
      @(negedge clk);
      g++;
    end
    if (!time_step) bad("ts_wait");
    w0 = cyc;
  endtask

  task automatic check_empty(input string nm);
    chk({nm, "_q_force"}, q_force.size(), 0);
    chk({nm, "_q_ts"}, q_ts.size(), 0);
    chk({nm, "_q_run"}, q_run.size(), 0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_ev_ready"}, ev_ready, 0);
    chk({nm, "_force_en"}, force_spike_en, 0);
    chk({nm, "_blk"}, force_spike_block_select, 0);
    chk({nm, "_nrn"}, force_spike_neuron_select, 0);
    chk({nm, "_time_step"}, time_step, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_step_count"}, step_count, 0);
    chk({nm, "_run_done"}, run_done, 0);
    chk({nm, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, g, n;
    reset = 1'b1; start = 1'b0; abort = 1'b0; num_steps = '0;
    ev_valid = 1'b0; ev_block = '0; ev_neuron = '0; ev_null = 1'b0; ev_last = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Three single-event steps
    start_run(3);
    for (int s = 0; s < 3; s++) send_ev(mk(2, 5, 1'b0, 1'b1));
    ev_valid = 1'b0;
    wait_idle("t1_idle");
    chk("t1_step_count", step_count, 3);
    check_empty("t1");

    // Four back-to-back events in one step
    start_run(1);
    send_ev(mk(1, 1, 1'b0, 1'b0));
    send_ev(mk(3, 7, 1'b0, 1'b0));
    send_ev(mk(0, 15, 1'b0, 1'b0));
    send_ev(mk(5, 2, 1'b0, 1'b1));
    ev_valid = 1'b0;
    wait_idle("t2_idle");
    chk("t2_step_count", step_count, 1);
    check_empty("t2");

    // Suppressed events still consumed, steps still issued
    start_run(3);
    send_ev(mk(1, 3, 1'b1, 1'b1));
    send_ev(mk(T, 4, 1'b0, 1'b1));
    send_ev(mk(7, 9, 1'b0, 1'b0));
    send_ev(mk(0, 0, 1'b1, 1'b1));
    ev_valid = 1'b0;
    wait_idle("t3_idle");
    chk("t3_step_count", step_count, 3);
    check_empty("t3");

    // done tied high: settle still honoured
    dmode = D_HIGH;
    start_run(2);
    send_ev(mk(4, 6, 1'b0, 1'b1));
    send_ev(mk(0, 8, 1'b0, 1'b1));
    ev_valid = 1'b0;
    wait_idle("t4h_idle");
    chk("t4h_step_count", step_count, 2);
    check_empty("t4h");

    // done tied low: timeout
    dmode = D_LOW;
    start_run(2);
    send_ev(mk(4, 4, 1'b0, 1'b1));
    ev_valid = 1'b0;
    wait_ts(w0);
    g = 0;
    while (!timeout_err && g < TIMEOUT + 10) begin
      @(negedge clk);
      g++;
    end
    chk("timeout_cyc", cyc, w0 + TIMEOUT);
    chk("timeout_busy", busy, 0);
    chk("timeout_step_count", step_count, 0);
    repeat (3) @(negedge clk);
    chk("timeout_sticky", timeout_err, 1);
    void'(q_run.pop_front());
    check_empty("t4l");

    // Zero-step run clears timeout_err, finishes at once
    dmode = D_RAND;
    start_run(0);
    chk("t6_timeout_cleared", timeout_err, 0);
    repeat (3) @(negedge clk);
    check_empty("t6z");

    // Abort during WAIT_DONE of step 2
    start_run(3);
    send_ev(mk(2, 5, 1'b0, 1'b1));
    ev_valid = 1'b0;
    g = 0;
    while (!ev_ready && g < 3 * TIMEOUT) begin
      @(negedge clk);
      g++;
    end
    dmode = D_LOW;
    send_ev(mk(3, 3, 1'b0, 1'b1));
    ev_valid = 1'b0;
    wait_ts(w0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_step_count", step_count, 1);
    chk("abort_ev_ready", ev_ready, 0);
    repeat (TIMEOUT + 5) @(negedge clk);
    chk("abort_no_timeout", timeout_err, 0);
    void'(q_run.pop_front());
    check_empty("t5");
    dmode = D_RAND;

    // Reset mid-run
    start_run(2);
    send_ev(mk(1, 2, 1'b0, 1'b0));
    ev_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    reset = 1'b0;
    q_force.delete();
    q_ts.delete();
    q_run.delete();
    @(negedge clk);

    // Randomised runs
    repeat (6) begin
      n = $urandom_range(1, 4);
      start_run(n);
      for (int s = 0; s < n; s++) send_step($urandom_range(1, 4));
      wait_idle("rand_idle");
      chk("rand_step_count", step_count, n);
      chk("rand_timeout_err", timeout_err, 0);
      check_empty("rand");
    end

    chk("ev_ready_outside_inject", ready_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
